// File: rtl/serial_sub.sv
// Digit-serial subtractor: d = a - b - bin over WIDTH bits, DIGIT bits per clock,
// with a registered borrow chain and valid/ready handshakes on input and output.
module serial_sub #(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 1,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int C  = WIDTH / DIGIT;
   localparam int CW = (C > 1) ? $clog2(C) : 1;

   generate
      if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
         $error("serial_sub: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic             r_brw;
   logic             r_bout;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [CW-1:0]    r_cnt;

   logic [DIGIT-1:0]       w_dig;
   logic [DIGIT:0]         w_bc;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]       w_d_next;
   logic                   w_last;
   logic                   w_ovf_next;

   // Ripple of DIGIT full subtractors on the low bits; w_bc[i] is the borrow into bit i.
   always_comb begin
      w_bc    = '0;
      w_dig   = '0;
      w_bc[0] = r_brw;
      for (int i = 0; i < DIGIT; i++) begin
         w_dig[i]  = r_a[i] ^ r_b[i] ^ w_bc[i];
         w_bc[i+1] = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_bc[i]);
      end
   end

   // New digit enters d from the MSB end; older digits move toward the LSB.
   always_comb begin
      w_cat      = {w_dig, r_d} >> DIGIT;
      w_d_next   = w_cat[WIDTH-1:0];
      w_last     = (r_cnt == CW'(C - 1));
      w_ovf_next = SIGNED ? (w_bc[DIGIT-1] ^ w_bc[DIGIT]) : w_bc[DIGIT];
   end

   // Control FSM with datapath shift registers and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_d         <= '0;
         r_brw       <= 1'b0;
         r_bout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_brw      <= bin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_a   <= r_a >> DIGIT;
               r_b   <= r_b >> DIGIT;
               r_d   <= w_d_next;
               r_brw <= w_bc[DIGIT];
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_bout      <= w_bc[DIGIT];
                  r_ovf       <= w_ovf_next;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign d         = r_d;
   assign bout      = r_bout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: scoreboard on a W=8,D=1,SIGNED=1 instance
// plus inline checks on a W=8,D=4,SIGNED=0 instance.
module tb_serial_sub;

   localparam int W = 8;
   localparam int D = 1;
   localparam bit S = 1'b1;
   localparam int C = W / D;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
   logic [W-1:0] a, b, d;
   logic         in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4, ovf4;
   logic [W-1:0] a4, b4, d4;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   bit  rnd_ready;
   logic or_man;
   logic prev_ov = 1'b0;

   typedef struct {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
      int           acc;
   } exp_t;
   exp_t q[$];

   serial_sub #(.WIDTH(W), .DIGIT(D), .SIGNED(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .bout(bout), .ovf(ovf)
   );

   serial_sub #(.WIDTH(W), .DIGIT(4), .SIGNED(1'b0)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .d(d4), .bout(bout4), .ovf(ovf4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic fbin, input bit sgn);
      exp_t e;
      int   ua, ub, t, sa, sb, ts;
      ua     = int'(fa);
      ub     = int'(fb);
      t      = ua - ub - int'(fbin);
      e.d    = t[W-1:0];
      e.bout = (t < 0);
      sa     = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb     = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      ts     = sa - sb - int'(fbin);
      e.ovf  = sgn ? ((ts < -(1 << (W - 1))) || (ts > (1 << (W - 1)) - 1)) : e.bout;
      e.acc  = 0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out (t=%0t)", nm, $time);
   endtask

   // Input monitor: every accepted operand set becomes an expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready) begin
         e     = model(a, b, bin, S);
         e.acc = cyc + 1;
         q.push_back(e);
      end
   end

   // Output monitor: compares every cycle the result is presented, pops on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            if (!prev_ov) chk("latency", cyc - q[0].acc, C);
            chk("d", {24'd0, d}, {24'd0, q[0].d});
            chk("bout", {31'd0, bout}, {31'd0, q[0].bout});
            chk("ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
            chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
            if (out_ready) void'(q.pop_front());
         end
      end
      prev_ov = out_valid && !rst;
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : or_man;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      in_valid = 1'b1; a = ta; b = tb; bin = tbin;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         step();
         n++;
      end
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if (!ok) timeout("accept");
   endtask

   task automatic wait_ov();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      if (!out_valid) timeout("out_valid");
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         step();
         n++;
      end
      if (q.size() != 0) timeout("drain");
   endtask

   task automatic dir(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      input logic [W-1:0] ed, input logic eb, input logic eo);
      op(ta, tb, tbin);
      wait_ov();
      chk("dir_d", {24'd0, d}, {24'd0, ed});
      chk("dir_bout", {31'd0, bout}, {31'd0, eb});
      chk("dir_ovf", {31'd0, ovf}, {31'd0, eo});
      wait_drain();
   endtask

   task automatic op4(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      exp_t e;
      bit   ok;
      int   n, lat;
      e  = model(ta, tb, tbin, 1'b0);
      ok = 1'b0;
      n  = 0;
      in_valid4 = 1'b1; a4 = ta; b4 = tb; bin4 = tbin;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready4;
         step();
         n++;
      end
      in_valid4 = 1'b0; a4 = 8'($urandom); b4 = 8'($urandom);
      if (!ok) timeout("accept4");
      lat = 0;
      while (!out_valid4 && lat < 50) begin
         step();
         lat++;
      end
      chk("latency4", lat, 32'd2);
      chk("d4", {24'd0, d4}, {24'd0, e.d});
      chk("bout4", {31'd0, bout4}, {31'd0, e.bout});
      chk("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
      step();
   endtask

   initial begin
      logic [W-1:0] held;
      rst = 1'b1; rnd_ready = 1'b0; or_man = 1'b1;
      in_valid = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b0;
      in_valid4 = 1'b0; a4 = 8'h00; b4 = 8'h00; bin4 = 1'b0; out_ready4 = 1'b1;
      repeat (3) step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_d", {24'd0, d}, 32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_no_capture", q.size(), 32'd0);
      chk("rst_in_ready4", {31'd0, in_ready4}, 32'd1);
      in_valid = 1'b0;
      rst = 1'b0;
      step();

      dir(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      dir(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      dir(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      dir(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      dir(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

      // Backpressure: result held in DONE while new operands are offered.
      or_man = 1'b0;
      step();
      op(8'h40, 8'h21, 1'b1);
      wait_ov();
      held = d;
      chk("bp_d_first", {24'd0, held}, 32'h1E);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
         step();
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_d_stable", {24'd0, d}, {24'd0, held});
      end
      in_valid = 1'b0;
      or_man = 1'b1;
      step();
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      wait_drain();

      // Reset in the third BUSY cycle aborts the operation.
      op(8'h33, 8'h11, 1'b0);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      q.delete();
      step();
      rst = 1'b0;
      step();
      dir(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

      // Reset while a result waits in DONE drops out_valid at once.
      or_man = 1'b0;
      step();
      op(8'h55, 8'h11, 1'b0);
      wait_ov();
      rst = 1'b1;
      #1;
      chk("donerst_out_valid", {31'd0, out_valid}, 32'd0);
      q.delete();
      step();
      rst = 1'b0;
      or_man = 1'b1;
      step();
      dir(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

      // Random operands, random gaps, random output backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         repeat ($urandom_range(0, 3)) step();
         op(8'($urandom), 8'($urandom), 1'($urandom));
      end
      rnd_ready = 1'b0;
      or_man = 1'b1;
      wait_drain();

      op4(8'hA5, 8'h5A, 1'b0);
      op4(8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 40; i++) begin
         op4(8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
